// File: rtl/clb_config_loader_if.sv
// Byte-stream configuration bus between an upstream byte source and the CLB
// configuration loader, carrying the committed CLB configuration back out.
interface clb_config_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [1:0] in1;
  logic [1:0] in2;
  logic       in3;
  logic       mux_in;
  logic       cfg_done;
  logic       cfg_err;
  logic [3:0] frame_cnt;
  logic       busy;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  in1,
    input  in2,
    input  in3,
    input  mux_in,
    input  cfg_done,
    input  cfg_err,
    input  frame_cnt,
    input  busy
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output in1,
    output in2,
    output in3,
    output mux_in,
    output cfg_done,
    output cfg_err,
    output frame_cnt,
    output busy
  );
endinterface

// File: rtl/clb_config_loader.sv
// Receives HDR/PAYLOAD/CHK frames over a valid/ready byte stream and commits
// the payload fields to a downstream CLB configuration only on a clean frame.
module clb_config_loader #(
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  clb_config_loader_if.slave   bus
);

  localparam int unsigned TW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PAY    = 3'd1,
    ST_CHK    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Expected check byte for a given payload.
  function automatic logic [7:0] frame_chk(input logic [7:0] pay);
    frame_chk = HDR ^ pay;
  endfunction

  // Reserved payload bits must be clear for a frame to be accepted.
  function automatic logic payload_ok(input logic [7:0] pay);
    payload_ok = (pay[7:6] == 2'b00);
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    shadow_r;
  logic [TW-1:0] tmo_r;
  logic          ready_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic [1:0]    in1_r;
  logic [1:0]    in2_r;
  logic          in3_r;
  logic          mux_r;
  logic [3:0]    cnt_r;

  logic          xfer_s;
  logic          tmo_hit_s;
  logic          chk_ok_s;
  logic          load_s;
  logic          in_frame_s;

  assign xfer_s     = bus.s_valid & ready_r;
  assign tmo_hit_s  = (tmo_r == TW'(TIMEOUT - 1));
  assign chk_ok_s   = (bus.s_data == frame_chk(shadow_r)) && payload_ok(shadow_r);
  assign load_s     = (state_r == ST_CHK) && (state_nxt_s == ST_COMMIT);
  assign in_frame_s = (state_r == ST_PAY) || (state_r == ST_CHK);

  // Next-state decode for the frame receiver.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s && (bus.s_data == HDR)) begin
          state_nxt_s = ST_PAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAY: begin
        if (xfer_s) begin
          state_nxt_s = ST_CHK;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_PAY;
        end
      end
      ST_CHK: begin
        if (xfer_s) begin
          state_nxt_s = chk_ok_s ? ST_COMMIT : ST_ERR;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_CHK;
        end
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      ST_ERR:    state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_PAY) ||
                 (state_nxt_s == ST_CHK);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_COMMIT);
      err_r   <= (state_nxt_s == ST_ERR);
    end
  end

  // Inter-byte idle counter; any transfer restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_r <= '0;
    end else if (xfer_s || ((state_r != ST_PAY) && (state_nxt_s == ST_PAY))) begin
      tmo_r <= '0;
    end else if (in_frame_s) begin
      tmo_r <= tmo_r + TW'(1);
    end else begin
      tmo_r <= tmo_r;
    end
  end

  // Payload shadow; dropped whenever the frame is rejected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= 8'h00;
    end else if ((state_r == ST_PAY) && xfer_s) begin
      shadow_r <= bus.s_data;
    end else if (state_nxt_s == ST_ERR) begin
      shadow_r <= 8'h00;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Committed configuration changes only on the CHK->COMMIT edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_r <= 1'b0;
      in1_r <= 2'b00;
      in2_r <= 2'b00;
      in3_r <= 1'b0;
      cnt_r <= 4'd0;
    end else if (load_s) begin
      mux_r <= shadow_r[0];
      in1_r <= shadow_r[2:1];
      in2_r <= shadow_r[4:3];
      in3_r <= shadow_r[5];
      cnt_r <= cnt_r + 4'd1;
    end else begin
      mux_r <= mux_r;
      in1_r <= in1_r;
      in2_r <= in2_r;
      in3_r <= in3_r;
      cnt_r <= cnt_r;
    end
  end

  assign bus.s_ready   = ready_r;
  assign bus.busy      = busy_r;
  assign bus.cfg_done  = done_r;
  assign bus.cfg_err   = err_r;
  assign bus.mux_in    = mux_r;
  assign bus.in1       = in1_r;
  assign bus.in2       = in2_r;
  assign bus.in3       = in3_r;
  assign bus.frame_cnt = cnt_r;

endmodule

// File: doc/clb_config_loader.md
CLB_CONFIG_LOADER -- requirements
Module: clb_config_loader

Interface
REQ-001 Parameter: HDR, default 8'hA5, frame sync byte.
REQ-002 Parameter: TIMEOUT, default 255, maximum number of idle cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 s_valid  input  1  upstream byte valid.
REQ-006 s_data  input  8  upstream configuration byte.
REQ-007 s_ready  output  1  loader accepts a byte this cycle.
REQ-008 in1  output  2  committed operand A for the downstream CLB.
REQ-009 in2  output  2  committed operand B for the downstream CLB.
REQ-010 in3  output  1  committed carry-in for the downstream CLB.
REQ-011 mux_in  output  1  committed output select for the downstream CLB (0 = combinational, 1 = registered).
REQ-012 cfg_done  output  1  one-cycle pulse when a frame commits.
REQ-013 cfg_err  output  1  one-cycle pulse when a frame is rejected.
REQ-014 frame_cnt  output  4  count of committed frames.
REQ-015 busy  output  1  high while a frame is in progress.

Function
REQ-016 A byte SHALL transfer only on a rising edge where s_valid=1 and s_ready=1.
REQ-017 Frame format SHALL be three bytes: HDR, PAYLOAD, CHK, where CHK = HDR ^ PAYLOAD.
REQ-018 PAYLOAD field map SHALL be: bit0 = mux_in, bits[2:1] = in1, bits[4:3] = in2, bit5 = in3, bits[7:6] = reserved and required to be 0.
REQ-019 The FSM SHALL have five states: IDLE, PAY, CHK, COMMIT, ERR.
REQ-020 s_ready SHALL be 1 in IDLE, PAY and CHK, and 0 in COMMIT and ERR.
REQ-021 IDLE: an accepted byte equal to HDR moves the FSM to PAY; any other accepted byte is discarded, the FSM stays in IDLE, and no error is raised.
REQ-022 PAY: the accepted byte is stored in a shadow register and the FSM moves to CHK; a byte equal to HDR is treated as ordinary payload (no resync).
REQ-023 CHK: on an accepted byte, if it matches the checksum and the reserved bits are 0, the FSM moves to COMMIT; otherwise it moves to ERR.
REQ-024 On the edge entering COMMIT, the outputs in1, in2, in3 and mux_in SHALL load from the shadow register, and frame_cnt SHALL increment.
REQ-025 cfg_done SHALL be 1 for exactly the single COMMIT cycle; the FSM then returns to IDLE.
REQ-026 Commit latency: the new configuration SHALL be visible in the cycle after the CHK byte is accepted.
REQ-027 ERR SHALL last one cycle with cfg_err=1; the committed outputs and frame_cnt stay unchanged; the FSM then returns to IDLE.
REQ-028 frame_cnt SHALL wrap from 15 to 0 without any flag.
REQ-029 Timeout counter: it clears on every accepted byte and on entry to PAY; it increments on each PAY/CHK cycle that has no transfer.
REQ-030 When the timeout counter reaches TIMEOUT, the FSM SHALL go to ERR, and the shadow register is discarded.
REQ-031 busy SHALL be 1 whenever the state is not IDLE.
REQ-032 Committed outputs SHALL change only on entry to COMMIT and SHALL hold their values indefinitely otherwise.

Reset
REQ-033 On assertion of reset, the following SHALL clear immediately (asynchronously): state = IDLE; in1, in2, in3, mux_in, frame_cnt, shadow register and timeout counter = 0; cfg_done = cfg_err = busy = 0.
REQ-034 s_ready SHALL be 0 while reset is asserted and 1 from the first cycle after deassertion.
REQ-035 Reset mid-frame SHALL abort the frame with no cfg_err pulse; the previously committed values are lost (reset to 0).

Verification
REQ-036 Good frame: A5, 2B, 8E sent back-to-back -> one cycle later mux_in=1, in1=01, in2=01, in3=1, cfg_done pulses once, frame_cnt=1.
REQ-037 Bad checksum: A5, 2B, 8F after a good frame -> cfg_err pulses once; outputs keep their previous values; frame_cnt unchanged.
REQ-038 Reserved bits set: A5, C0, 65 -> cfg_err pulses once; no commit occurs.
REQ-039 Garbage then frame: 00, 13, A5, 01, A4 -> bytes 00 and 13 discarded silently; then mux_in=1 with all other fields 0, and cfg_done pulses once.
REQ-040 Timeout: A5, 2B, then s_valid held low for TIMEOUT cycles -> cfg_err pulses once, busy drops, outputs unchanged.
REQ-041 Wrap and reset: 16 good frames -> frame_cnt=0; then reset asserted while in CHK -> all outputs 0 immediately, no cfg_err, s_ready=1 the cycle after release.
